// File: rtl/vga_pixel_pipe_pkg.sv
// Shared display-path definitions: widths, sync idle level, visible grid and RGB332->RGB444 palette expansion.
package gpu_defs;
  localparam int PIX_POS_W = 16;
  localparam int RGB332_W  = 8;
  localparam int DAC_W     = 4;
  localparam int GRID_W    = 200;
  localparam int GRID_H    = 150;
  localparam logic SYNC_IDLE = 1'b1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic disp;
  } ctl_t;

  localparam ctl_t CTL_RST = '{hs: SYNC_IDLE, vs: SYNC_IDLE, disp: 1'b0};

  typedef struct packed {
    logic [DAC_W-1:0] r;
    logic [DAC_W-1:0] g;
    logic [DAC_W-1:0] b;
  } rgb_t;

  // Replicate the MSBs into the low bits so full-scale input maps to full-scale DAC code.
  function automatic rgb_t rgb332_to_444(input logic [RGB332_W-1:0] d);
    rgb_t c;
    c.r = {d[7:5], d[7]};
    c.g = {d[4:2], d[4]};
    c.b = {d[1:0], d[1:0]};
    return c;
  endfunction
endpackage

// File: rtl/vga_pixel_pipe_sig_delay.sv
// N-stage shift register with a parameterised reset value; output is the last stage.
module sig_delay #(
  parameter int W = 1,
  parameter int N = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [N-1:0][W-1:0] stg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q <= {N{RST_VAL}};
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < N; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign q_o = stg_q[N-1];
endmodule

// File: rtl/vga_pixel_pipe.sv
// VGA pixel pipe: framebuffer fetch, RGB332->RGB444 expansion, sync/blank alignment, frame counter and vblank irq.
module vga_pixel_pipe
  import gpu_defs::*;
#(
  parameter int RD_LAT = 1,
  parameter int FC_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 h_sync_i,
  input  logic                 v_sync_i,
  input  logic                 in_disp_i,
  input  logic [PIX_POS_W-1:0] pixel_pos_i,
  output logic [PIX_POS_W-1:0] vram_addr_o,
  input  logic [RGB332_W-1:0]  vram_rdata_i,
  output logic [DAC_W-1:0]     vga_r_o,
  output logic [DAC_W-1:0]     vga_g_o,
  output logic [DAC_W-1:0]     vga_b_o,
  output logic                 h_sync_o,
  output logic                 v_sync_o,
  output logic [FC_W-1:0]      frame_cnt_o,
  output logic                 vblank_irq_o,
  input  logic                 irq_ack_i
);
  localparam int PIPE = RD_LAT + 2;

  ctl_t ctl_in, ctl_tap;
  assign ctl_in = '{hs: h_sync_i, vs: v_sync_i, disp: in_disp_i};

  // Tap PIPE-1 lines up with the RAM data; the output registers add the last cycle.
  sig_delay #(
    .W      ($bits(ctl_t)),
    .N      (PIPE-1),
    .RST_VAL(CTL_RST)
  ) u_ctl_dly (
    .clk (clk),
    .rst (rst),
    .d_i (ctl_in),
    .q_o (ctl_tap)
  );

  logic [PIX_POS_W-1:0] addr_q;
  rgb_t                 rgb_q, rgb_d;
  logic                 hs_q, vs_q;
  logic [FC_W-1:0]      cnt_q, cnt_d;
  logic                 irq_q, irq_d;
  logic                 vs_prev_q, armed_q;
  logic                 frame_end;

  // armed_q masks the first cycle after reset so a v_sync_i already low on release is not a frame end.
  always_comb begin
    rgb_d     = '0;
    cnt_d     = cnt_q;
    irq_d     = irq_q;
    frame_end = armed_q & vs_prev_q & ~v_sync_i;
    if (ctl_tap.disp) rgb_d = rgb332_to_444(vram_rdata_i);
    if (frame_end) begin
      cnt_d = cnt_q + 1'b1;
      irq_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      rgb_q     <= '0;
      hs_q      <= SYNC_IDLE;
      vs_q      <= SYNC_IDLE;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
      vs_prev_q <= SYNC_IDLE;
      armed_q   <= 1'b0;
    end else begin
      addr_q    <= pixel_pos_i;
      rgb_q     <= rgb_d;
      hs_q      <= ctl_tap.hs;
      vs_q      <= ctl_tap.vs;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
      vs_prev_q <= v_sync_i;
      armed_q   <= 1'b1;
    end
  end

  assign vram_addr_o  = addr_q;
  assign vga_r_o      = rgb_q.r;
  assign vga_g_o      = rgb_q.g;
  assign vga_b_o      = rgb_q.b;
  assign h_sync_o     = hs_q;
  assign v_sync_o     = vs_q;
  assign frame_cnt_o  = cnt_q;
  assign vblank_irq_o = irq_q;
endmodule
